ext_bus_responder: RTL

- Responder (slave) end of the 16-bit external bus driven by the Avalon-to-external-bus bridge in the Nios system.
- Decodes bridge cycles and returns acknowledge and read data from an 8-word register bank.
- Contains a reload countdown timer and an edge-detected event input, which together drive the bridge irq line.
- One instance sits on each bridge port of the arbitration demo.

---
 rtl/ext_bus_resp_pkg.sv | 39 +++
 rtl/ext_bus_resp_timer.sv | 36 +++
 rtl/ext_bus_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ext_bus_resp_pkg.sv
// Shared types and constants for the external-bus responder: FSM states,
// register word indices, CTRL/STATUS bit positions and a byte-lane merge helper.
package ext_bus_resp_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [2:0] REG_SCRATCH0 = 3'd0;
  localparam logic [2:0] REG_SCRATCH1 = 3'd1;
  localparam logic [2:0] REG_SCRATCH2 = 3'd2;
  localparam logic [2:0] REG_SCRATCH3 = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_RELOAD   = 3'd5;
  localparam logic [2:0] REG_COUNT    = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int CTRL_TMR_IE = 0;
  localparam int CTRL_EVT_IE = 1;
  localparam int CTRL_RUN    = 2;

  localparam int STAT_TMR_HIT = 0;
  localparam int STAT_EVT_HIT = 1;

  // Replace only the byte lanes selected by be; unselected lanes keep old_v.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [1:0]        be);
    merge_bytes = old_v;
    if (be[0]) merge_bytes[7:0]  = new_v[7:0];
    if (be[1]) merge_bytes[15:8] = new_v[15:8];
  endfunction

endpackage

// File: rtl/ext_bus_resp_timer.sv
// Reload countdown timer: holds RELOAD and COUNT, reloads on zero and flags a
// hit for that cycle. Only present in builds with EXT_BUS_RESP_TIMER_EN.
module ext_bus_resp_timer
  import ext_bus_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  input  logic              reload_we,
  input  logic [1:0]        reload_be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] reload,
  output logic [DATA_W-1:0] count,
  output logic              hit
);

  // A hit is the cycle in which a running COUNT sits at zero and wraps.
  assign hit = run && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
      count  <= '0;
    end else begin
      if (reload_we) reload <= merge_bytes(reload, wdata, reload_be);
      // load only fires on a run 0->1 write, so it never overlaps a running step
      if (load) begin
        count <= reload;
      end else if (run) begin
        count <= (count == '0) ? reload : count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Responder end of the 16-bit external bridge bus: 8-word register bank,
// event-driven irq, and an optional countdown timer (macro EXT_BUS_RESP_TIMER_EN).
module ext_bus_responder
  import ext_bus_resp_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int BASE_HI     = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              bus_enable,
  input  logic [1:0]        byte_enable,
  input  logic              rw,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              acknowledge,
  output logic              irq,
  input  logic              event_in
);

  localparam logic [ADDR_W-5:0] BASE_V  = BASE_HI[ADDR_W-5:0];
  localparam logic [3:0]        WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef EXT_BUS_RESP_TIMER_EN
  localparam logic [2:0]        CTRL_MASK = 3'b111;
`else
  localparam logic [2:0]        CTRL_MASK = 3'b010;
`endif

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt;
  logic [ADDR_W-1:1]   addr_q;
  logic                rw_q;
  logic [1:0]          be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          widx;
  logic                in_range;
  logic                ack_nxt;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_mux;

  logic [3:0][DATA_W-1:0] scratch;
  logic [2:0]          ctrl;
  logic [1:0]          status;
  logic                ctrl_we;
  logic [1:0]          status_set;
  logic [1:0]          status_clr;
  logic                ev_s1, ev_s2, ev_d;
  logic                ev_rise;
  logic                tmr_hit;
  logic [DATA_W-1:0]   reload_v;
  logic [DATA_W-1:0]   count_v;

  assign widx     = addr_q[3:1];
  assign in_range = (addr_q[ADDR_W-1:4] == BASE_V);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_enable) state_nxt = (WAIT_STATES > 0) ? WAIT : ACK;
      WAIT:    if (wait_cnt == WS_LAST) state_nxt = ACK;
      ACK:     state_nxt = HOLD;
      HOLD:    if (!bus_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    if (state == ACK) begin
      ack_nxt = 1'b1;
      wr_en   = !rw_q && in_range;
      rd_en   = rw_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else wait_cnt <= '0;
  end

  // Request capture and registered bus outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_q      <= '0;
      rw_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      acknowledge <= 1'b0;
      read_data   <= '0;
    end else begin
      if (state == IDLE && bus_enable) begin
        addr_q  <= address[ADDR_W-1:1];
        rw_q    <= rw;
        be_q    <= byte_enable;
        wdata_q <= write_data;
      end
      acknowledge <= ack_nxt;
      if (rd_en) read_data <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      case (widx)
        REG_SCRATCH0, REG_SCRATCH1,
        REG_SCRATCH2, REG_SCRATCH3: rd_mux = scratch[widx[1:0]];
        REG_CTRL:                   rd_mux = {13'd0, ctrl};
        REG_RELOAD:                 rd_mux = reload_v;
        REG_COUNT:                  rd_mux = count_v;
        REG_STATUS:                 rd_mux = {14'd0, status};
        default:                    rd_mux = '0;
      endcase
    end
  end

  assign ctrl_we    = wr_en && (widx == REG_CTRL) && be_q[0];
  assign status_clr = (wr_en && (widx == REG_STATUS) && be_q[0]) ? wdata_q[1:0] : 2'b00;
  assign ev_rise    = ev_s2 && !ev_d;
  assign status_set = {ev_rise, tmr_hit};

`ifdef EXT_BUS_RESP_TIMER_EN
  ext_bus_resp_timer u_timer (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .run       (ctrl[CTRL_RUN]),
    .load      (ctrl_we && wdata_q[CTRL_RUN] && !ctrl[CTRL_RUN]),
    .reload_we (wr_en && (widx == REG_RELOAD)),
    .reload_be (be_q),
    .wdata     (wdata_q),
    .reload    (reload_v),
    .count     (count_v),
    .hit       (tmr_hit)
  );
`else
  assign tmr_hit  = 1'b0;
  assign reload_v = '0;
  assign count_v  = '0;
`endif

  // Register bank, event synchronizer and irq; a status set beats a same-cycle W1C
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scratch <= '0;
      ctrl    <= '0;
      status  <= '0;
      irq     <= 1'b0;
      ev_s1   <= 1'b0;
      ev_s2   <= 1'b0;
      ev_d    <= 1'b0;
    end else begin
      if (wr_en && !widx[2]) begin
        scratch[widx[1:0]] <= merge_bytes(scratch[widx[1:0]], wdata_q, be_q);
      end
      if (ctrl_we) ctrl <= wdata_q[2:0] & CTRL_MASK;
      status <= (status & ~status_clr) | status_set;
      irq    <= |(status & ctrl[CTRL_EVT_IE:CTRL_TMR_IE]);
      ev_s1  <= event_in;
      ev_s2  <= ev_s1;
      ev_d   <= ev_s2;
    end
  end

endmodule
